// File: rtl/alu_uart_interface.sv
// Frame sequencer between a UART byte rx/tx pair and a combinational ALU.
// Collects ope1, ope2 and opcode, runs the ALU once, then ships the result.
module alu_uart_interface #(
    parameter int BUS_LEN        = 8,
    parameter int OPCODE_LEN     = 6,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [BUS_LEN-1:0]    i_rx_data,
    input  logic                  i_rx_done,
    output logic [BUS_LEN-1:0]    o_ope1,
    output logic [BUS_LEN-1:0]    o_ope2,
    output logic [OPCODE_LEN-1:0] o_opcode,
    input  logic [BUS_LEN-1:0]    i_result,
    output logic [BUS_LEN-1:0]    o_tx_data,
    output logic                  o_tx_start,
    input  logic                  i_tx_done,
    output logic                  o_timeout,
    output logic                  o_busy
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
    localparam logic [CW-1:0] LAST =
        TO_EN ? CW'(TIMEOUT_CYCLES - 1) : '0;

    typedef enum logic [2:0] {
        WAIT_OPE1,
        WAIT_OPE2,
        WAIT_OPCODE,
        EXEC,
        WAIT_TX
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= WAIT_OPE1;
            cnt        <= '0;
            o_ope1     <= '0;
            o_ope2     <= '0;
            o_opcode   <= '0;
            o_tx_data  <= '0;
            o_tx_start <= 1'b0;
            o_timeout  <= 1'b0;
            o_busy     <= 1'b0;
        end else begin
            o_tx_start <= 1'b0;
            o_timeout  <= 1'b0;
            unique case (state)
                WAIT_OPE1: begin
                    if (i_rx_done) begin
                        o_ope1 <= i_rx_data;
                        cnt    <= '0;
                        o_busy <= 1'b1;
                        state  <= WAIT_OPE2;
                    end
                end
                WAIT_OPE2: begin
                    if (i_rx_done) begin
                        o_ope2 <= i_rx_data;
                        cnt    <= '0;
                        state  <= WAIT_OPCODE;
                    end else if (TO_EN && cnt == LAST) begin
                        o_timeout <= 1'b1;
                        o_busy    <= 1'b0;
                        cnt       <= '0;
                        state     <= WAIT_OPE1;
                    end else if (TO_EN) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_OPCODE: begin
                    if (i_rx_done) begin
                        o_opcode <= i_rx_data[OPCODE_LEN-1:0];
                        cnt      <= '0;
                        state    <= EXEC;
                    end else if (TO_EN && cnt == LAST) begin
                        o_timeout <= 1'b1;
                        o_busy    <= 1'b0;
                        cnt       <= '0;
                        state     <= WAIT_OPE1;
                    end else if (TO_EN) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                EXEC: begin
                    o_tx_data  <= i_result;
                    o_tx_start <= 1'b1;
                    state      <= WAIT_TX;
                end
                WAIT_TX: begin
                    // a done pulse overlapping our own start pulse is stale
                    if (i_tx_done && !o_tx_start) begin
                        o_busy <= 1'b0;
                        state  <= WAIT_OPE1;
                    end
                end
                default: begin
                    o_busy <= 1'b0;
                    state  <= WAIT_OPE1;
                end
            endcase
        end
    end

endmodule
